sc_downtransitioncounter: RTL and testbench

//  Loadable down-counter that decrements once per high-to-low transition of an active-low request.
//  It is the countdown counterpart of the up-transition counter.

---
 rtl/sc_counter_pkg.sv | 30 +++
 rtl/sc_fallingedge_detect.sv | 37 +++
 rtl/sc_downtransitioncounter.sv | 145 ++++++++++++++
 tb/tb_sc_downtransitioncounter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sc_counter_pkg.sv
// -----------------------------------------------------------------------------
// sc_counter_pkg
// Shared definitions for the small transition-counter family used by the game
// logic (up/down transition counters, edge detectors).
//
// Contents:
//   DOWNTRANSITIONCOUNTER_DATAWIDTH_DEFAULT : default count / bus width
//   ST_IDLE / ST_COUNT / ST_DONE           : counter FSM state encoding
//   scStateName()                          : readable state name helper
// -----------------------------------------------------------------------------
package sc_counter_pkg;

    localparam int DOWNTRANSITIONCOUNTER_DATAWIDTH_DEFAULT = 8;

    // Counter FSM encoding. The fourth code is unused and treated as IDLE.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Readable state name, handy for simulation printouts.
    function automatic string scStateName(input logic [1:0] st);
        case (st)
            ST_IDLE:  return "IDLE";
            ST_COUNT: return "COUNT";
            ST_DONE:  return "DONE";
            default:  return "ILLEGAL";
        endcase
    endfunction

endpackage

// File: rtl/sc_fallingedge_detect.sv
// -----------------------------------------------------------------------------
// sc_fallingedge_detect
// Detects a 1->0 transition on an active-low level input. The previous-level
// register resets to 1 so a request that is already low when reset releases
// produces a pulse on the first sampled cycle (it really did fall from the
// idle-high assumption); a request held low produces exactly one pulse.
//
// Ports:
//   SC_FALLINGEDGE_DETECT_CLOCK_50      in  1  rising-edge clock
//   SC_FALLINGEDGE_DETECT_RESET_InHigh  in  1  synchronous active-high reset
//   SC_FALLINGEDGE_DETECT_level_InLow   in  1  active-low level being watched
//   SC_FALLINGEDGE_DETECT_fall_OutPulse out 1  high in the cycle the level is
//                                              low and was high last cycle
// -----------------------------------------------------------------------------
module sc_fallingedge_detect (
    input  logic SC_FALLINGEDGE_DETECT_CLOCK_50,
    input  logic SC_FALLINGEDGE_DETECT_RESET_InHigh,
    input  logic SC_FALLINGEDGE_DETECT_level_InLow,
    output logic SC_FALLINGEDGE_DETECT_fall_OutPulse
);

    logic prevLevel_reg;

    always_ff @(posedge SC_FALLINGEDGE_DETECT_CLOCK_50) begin
        if (SC_FALLINGEDGE_DETECT_RESET_InHigh) begin
            prevLevel_reg <= 1'b1;
        end else begin
            prevLevel_reg <= SC_FALLINGEDGE_DETECT_level_InLow;
        end
    end

    // Combinational so the owning counter reacts at the same edge that
    // samples the low level.
    assign SC_FALLINGEDGE_DETECT_fall_OutPulse =
        prevLevel_reg & ~SC_FALLINGEDGE_DETECT_level_InLow;

endmodule

// File: rtl/sc_downtransitioncounter.sv
// -----------------------------------------------------------------------------
// sc_downtransitioncounter
// Loadable down-counter decrementing once per high-to-low transition of an
// active-low request. Used for countdown timers, lives and obstacle delays.
// Flags zero and emits a one-cycle done pulse when the count expires.
//
// Build option:
//   DOWNTRANSITIONCOUNTER_AUTORELOAD_EN  when defined, a reload register keeps
//       the last loaded value and a 1->0 step restarts the count from it
//       (done still pulses, state stays COUNT). A reload value of 0 behaves
//       like the plain build.
//
// Ports (W = DOWNTRANSITIONCOUNTER_DATAWIDTH):
//   SC_DOWNTRANSITIONCOUNTER_CLOCK_50         in  1  rising-edge clock
//   SC_DOWNTRANSITIONCOUNTER_RESET_InHigh     in  1  synchronous active-high reset
//   SC_DOWNTRANSITIONCOUNTER_load_InLow       in  1  0 = load data_InBUS
//   SC_DOWNTRANSITIONCOUNTER_data_InBUS       in  W  value to load
//   SC_DOWNTRANSITIONCOUNTER_downcount_InLow  in  1  active-low request
//   SC_DOWNTRANSITIONCOUNTER_data_OutBUS      out W  current count (registered)
//   SC_DOWNTRANSITIONCOUNTER_zero_Out         out 1  IDLE/DONE or count==0
//   SC_DOWNTRANSITIONCOUNTER_done_OutPulse    out 1  one-cycle pulse on 1->0
// -----------------------------------------------------------------------------
module sc_downtransitioncounter
    import sc_counter_pkg::*;
#(
    parameter int DOWNTRANSITIONCOUNTER_DATAWIDTH = DOWNTRANSITIONCOUNTER_DATAWIDTH_DEFAULT
) (
    input  logic                                       SC_DOWNTRANSITIONCOUNTER_CLOCK_50,
    input  logic                                       SC_DOWNTRANSITIONCOUNTER_RESET_InHigh,
    input  logic                                       SC_DOWNTRANSITIONCOUNTER_load_InLow,
    input  logic [DOWNTRANSITIONCOUNTER_DATAWIDTH-1:0] SC_DOWNTRANSITIONCOUNTER_data_InBUS,
    input  logic                                       SC_DOWNTRANSITIONCOUNTER_downcount_InLow,
    output logic [DOWNTRANSITIONCOUNTER_DATAWIDTH-1:0] SC_DOWNTRANSITIONCOUNTER_data_OutBUS,
    output logic                                       SC_DOWNTRANSITIONCOUNTER_zero_Out,
    output logic                                       SC_DOWNTRANSITIONCOUNTER_done_OutPulse
);

    localparam int W = DOWNTRANSITIONCOUNTER_DATAWIDTH;
    localparam logic [W-1:0] COUNT_ZERO = '0;
    localparam logic [W-1:0] COUNT_ONE  = W'(1);

    logic [1:0]   state_reg, state_next;
    logic [W-1:0] count_reg, count_next;
    logic         done_reg,  done_next;
    logic         fallPulse;

`ifdef DOWNTRANSITIONCOUNTER_AUTORELOAD_EN
    logic [W-1:0] reload_reg, reload_next;
`endif

    // -------------------------------------------------------------------------
    // Request edge detector
    // -------------------------------------------------------------------------
    sc_fallingedge_detect uFallDetect (
        .SC_FALLINGEDGE_DETECT_CLOCK_50      (SC_DOWNTRANSITIONCOUNTER_CLOCK_50),
        .SC_FALLINGEDGE_DETECT_RESET_InHigh  (SC_DOWNTRANSITIONCOUNTER_RESET_InHigh),
        .SC_FALLINGEDGE_DETECT_level_InLow   (SC_DOWNTRANSITIONCOUNTER_downcount_InLow),
        .SC_FALLINGEDGE_DETECT_fall_OutPulse (fallPulse)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge SC_DOWNTRANSITIONCOUNTER_CLOCK_50) begin
        if (SC_DOWNTRANSITIONCOUNTER_RESET_InHigh) begin
            state_reg  <= ST_IDLE;
            count_reg  <= COUNT_ZERO;
            done_reg   <= 1'b0;
`ifdef DOWNTRANSITIONCOUNTER_AUTORELOAD_EN
            reload_reg <= COUNT_ZERO;
`endif
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            done_reg   <= done_next;
`ifdef DOWNTRANSITIONCOUNTER_AUTORELOAD_EN
            reload_reg <= reload_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next state / next count. Load has priority over a fall; a fall only
    // matters in COUNT, so IDLE and DONE can never underflow.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        done_next   = 1'b0;
`ifdef DOWNTRANSITIONCOUNTER_AUTORELOAD_EN
        reload_next = reload_reg;
`endif

        if (!SC_DOWNTRANSITIONCOUNTER_load_InLow) begin
            count_next = SC_DOWNTRANSITIONCOUNTER_data_InBUS;
            state_next = (SC_DOWNTRANSITIONCOUNTER_data_InBUS != COUNT_ZERO) ? ST_COUNT : ST_DONE;
`ifdef DOWNTRANSITIONCOUNTER_AUTORELOAD_EN
            reload_next = SC_DOWNTRANSITIONCOUNTER_data_InBUS;
`endif
        end else begin
            case (state_reg)
                ST_COUNT: begin
                    if (fallPulse) begin
                        if (count_reg > COUNT_ONE) begin
                            count_next = count_reg - COUNT_ONE;
                        end else if (count_reg == COUNT_ONE) begin
                            done_next = 1'b1;
`ifdef DOWNTRANSITIONCOUNTER_AUTORELOAD_EN
                            if (reload_reg != COUNT_ZERO) begin
                                count_next = reload_reg;
                                state_next = ST_COUNT;
                            end else begin
                                count_next = COUNT_ZERO;
                                state_next = ST_DONE;
                            end
`else
                            count_next = COUNT_ZERO;
                            state_next = ST_DONE;
`endif
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                    // Falls are ignored until the next load.
                end
                default: begin
                    // Unused encoding: recover to a clean idle.
                    state_next = ST_IDLE;
                    count_next = COUNT_ZERO;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        SC_DOWNTRANSITIONCOUNTER_zero_Out = (state_reg != ST_COUNT) || (count_reg == COUNT_ZERO);
    end

    assign SC_DOWNTRANSITIONCOUNTER_data_OutBUS   = count_reg;
    assign SC_DOWNTRANSITIONCOUNTER_done_OutPulse = done_reg;

endmodule

// File: tb/tb_sc_downtransitioncounter.sv
// -----------------------------------------------------------------------------
// tb_sc_downtransitioncounter
// Directed stimulus with hand-computed expectations pushed into a scoreboard
// queue; a monitor pops one expectation per clock and compares all outputs.
// -----------------------------------------------------------------------------
module tb_sc_downtransitioncounter;

`ifdef DOWNTRANSITIONCOUNTER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       loadN = 1'b1;
    logic [7:0] dataIn = 8'd0;
    logic       downN = 1'b1;
    logic [7:0] dataOut;
    logic       zeroOut;
    logic       doneOut;

    always #5 clk = ~clk;

    sc_downtransitioncounter #(.DOWNTRANSITIONCOUNTER_DATAWIDTH(8)) dut (
        .SC_DOWNTRANSITIONCOUNTER_CLOCK_50        (clk),
        .SC_DOWNTRANSITIONCOUNTER_RESET_InHigh    (rst),
        .SC_DOWNTRANSITIONCOUNTER_load_InLow      (loadN),
        .SC_DOWNTRANSITIONCOUNTER_data_InBUS      (dataIn),
        .SC_DOWNTRANSITIONCOUNTER_downcount_InLow (downN),
        .SC_DOWNTRANSITIONCOUNTER_data_OutBUS     (dataOut),
        .SC_DOWNTRANSITIONCOUNTER_zero_Out        (zeroOut),
        .SC_DOWNTRANSITIONCOUNTER_done_OutPulse   (doneOut)
    );

    typedef struct packed {
        logic [7:0] cnt;
        logic       zero;
        logic       done;
    } exp_t;

    exp_t  expQ[$];
    string nameQ[$];
    int    compared   = 0;
    int    mismatched = 0;

    // Drive one cycle of inputs and record what the outputs must be after
    // the coming rising edge.
    task automatic step(input logic r, input logic ld, input logic [7:0] d,
                        input logic dc, input logic [7:0] ec, input logic ez,
                        input logic ed, input string nm);
        exp_t e;
        @(negedge clk);
        rst = r; loadN = ld; dataIn = d; downN = dc;
        e.cnt = ec; e.zero = ez; e.done = ed;
        expQ.push_back(e);
        nameQ.push_back(nm);
    endtask

    // Monitor: one expectation consumed per clock, sampled 1ns after the edge.
    always begin
        exp_t  e;
        string nm;
        @(posedge clk);
        #1;
        if (expQ.size() > 0) begin
            e  = expQ.pop_front();
            nm = nameQ.pop_front();
            compared += 3;
            if (dataOut !== e.cnt) begin
                mismatched++;
                $display("FAIL %s count: got %0d expected %0d", nm, dataOut, e.cnt);
            end
            if (zeroOut !== e.zero) begin
                mismatched++;
                $display("FAIL %s zero: got %b expected %b", nm, zeroOut, e.zero);
            end
            if (doneOut !== e.done) begin
                mismatched++;
                $display("FAIL %s done: got %b expected %b", nm, doneOut, e.done);
            end
            $display("%0t %-14s cnt=%0d zero=%b done=%b", $time, nm, dataOut, zeroOut, doneOut);
        end
    end

    initial begin
        // 1. Reset with random inputs, then an ignored fall in IDLE
        step(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 8'd0, 1'b1, 1'b0, "rst_a");
        step(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 8'd0, 1'b1, 1'b0, "rst_b");
        step(1'b0, 1'b1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0, "idle");
        step(1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, "idle_fall");
        step(1'b0, 1'b1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0, "idle_rel");

        // 2. Load 3, three falls, then a fourth
        step(1'b0, 1'b0, 8'd3, 1'b1, 8'd3, 1'b0, 1'b0, "ld3");
        step(1'b0, 1'b1, 8'd0, 1'b0, 8'd2, 1'b0, 1'b0, "f1");
        step(1'b0, 1'b1, 8'd0, 1'b1, 8'd2, 1'b0, 1'b0, "r1");
        step(1'b0, 1'b1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, "f2");
        step(1'b0, 1'b1, 8'd0, 1'b1, 8'd1, 1'b0, 1'b0, "r2");
        step(1'b0, 1'b1, 8'd0, 1'b0, AR ? 8'd3 : 8'd0, AR ? 1'b0 : 1'b1, 1'b1, "f3_done");
        step(1'b0, 1'b1, 8'd0, 1'b1, AR ? 8'd3 : 8'd0, AR ? 1'b0 : 1'b1, 1'b0, "r3");
        step(1'b0, 1'b1, 8'd0, 1'b0, AR ? 8'd2 : 8'd0, AR ? 1'b0 : 1'b1, 1'b0, "f4");
        step(1'b0, 1'b1, 8'd0, 1'b1, AR ? 8'd2 : 8'd0, AR ? 1'b0 : 1'b1, 1'b0, "r4");

        // 3. Load 5, hold low for 10 clocks -> one decrement only
        step(1'b0, 1'b0, 8'd5, 1'b1, 8'd5, 1'b0, 1'b0, "ld5");
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 8'd0, 1'b0, 8'd4, 1'b0, 1'b0, "hold_low");
        step(1'b0, 1'b1, 8'd0, 1'b1, 8'd4, 1'b0, 1'b0, "hold_rel");
        step(1'b0, 1'b1, 8'd0, 1'b0, 8'd3, 1'b0, 1'b0, "press2");
        step(1'b0, 1'b1, 8'd0, 1'b1, 8'd3, 1'b0, 1'b0, "press2_rel");

        // 4. Load and fall together; load 0; load maximum
        step(1'b0, 1'b0, 8'd2, 1'b0, 8'd2, 1'b0, 1'b0, "ld2_fall");
        step(1'b0, 1'b1, 8'd0, 1'b1, 8'd2, 1'b0, 1'b0, "ld2_hold");
        step(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0, "ld0");
        step(1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, "done_fall");
        step(1'b0, 1'b0, 8'd255, 1'b1, 8'd255, 1'b0, 1'b0, "ld255");
        step(1'b0, 1'b1, 8'd0, 1'b0, 8'd254, 1'b0, 1'b0, "f255");
        step(1'b0, 1'b1, 8'd0, 1'b1, 8'd254, 1'b0, 1'b0, "r255");

        // 5. Reset mid-count aborts without a done pulse
        step(1'b0, 1'b0, 8'd4, 1'b1, 8'd4, 1'b0, 1'b0, "ld4");
        step(1'b0, 1'b1, 8'd0, 1'b0, 8'd3, 1'b0, 1'b0, "f4a");
        step(1'b0, 1'b1, 8'd0, 1'b1, 8'd3, 1'b0, 1'b0, "r4a");
        step(1'b0, 1'b1, 8'd0, 1'b0, 8'd2, 1'b0, 1'b0, "f4b");
        step(1'b1, 1'b1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0, "rst_mid");
        step(1'b0, 1'b1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0, "post_rst");
        step(1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, "post_rst_fall");
        step(1'b0, 1'b1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0, "post_rst_rel");

        // 6. Load 2, four falls (reload behaviour when enabled)
        step(1'b0, 1'b0, 8'd2, 1'b1, 8'd2, 1'b0, 1'b0, "ar_ld2");
        step(1'b0, 1'b1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, "ar_f1");
        step(1'b0, 1'b1, 8'd0, 1'b1, 8'd1, 1'b0, 1'b0, "ar_r1");
        step(1'b0, 1'b1, 8'd0, 1'b0, AR ? 8'd2 : 8'd0, AR ? 1'b0 : 1'b1, 1'b1, "ar_f2");
        step(1'b0, 1'b1, 8'd0, 1'b1, AR ? 8'd2 : 8'd0, AR ? 1'b0 : 1'b1, 1'b0, "ar_r2");
        step(1'b0, 1'b1, 8'd0, 1'b0, AR ? 8'd1 : 8'd0, AR ? 1'b0 : 1'b1, 1'b0, "ar_f3");
        step(1'b0, 1'b1, 8'd0, 1'b1, AR ? 8'd1 : 8'd0, AR ? 1'b0 : 1'b1, 1'b0, "ar_r3");
        step(1'b0, 1'b1, 8'd0, 1'b0, AR ? 8'd2 : 8'd0, AR ? 1'b0 : 1'b1, AR, "ar_f4");
        step(1'b0, 1'b1, 8'd0, 1'b1, AR ? 8'd2 : 8'd0, AR ? 1'b0 : 1'b1, 1'b0, "ar_r4");

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
